// File: rtl/mips32_fetch_queue.sv
// Fetch front end: owns the fetch PC, reads instruction memory over req/ack and
// buffers {pc, instr} pairs in a DEPTH-entry FIFO. Optional macro: FETCH_HALT_DETECT_EN.
module mips32_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] HALT_PC  = 32'h8
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     fetch_pc_q;
  logic            kill_q;
  logic            rst_q;
  logic            halted_q;
  logic [31:0]     pc_mem_q    [DEPTH];
  logic [31:0]     instr_mem_q [DEPTH];

  logic full, push, pop;

  // Full is judged on the current count, before any pop in the same cycle.
  assign full     = (count_q == CntW'(DEPTH));
  assign imem_req = !rst_q && !kill_q && !halted_q && !full;
  assign push     = imem_req && imem_ack;
  assign pop      = instr_valid && instr_ready;

  assign imem_addr   = fetch_pc_q;
  assign instr_valid = (count_q != '0);
  assign instr_out   = instr_valid ? instr_mem_q[head_q] : 32'h0;
  assign pc_out      = instr_valid ? pc_mem_q[head_q] : 32'h0;
  assign halted      = halted_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      kill_q     <= 1'b0;
      rst_q      <= 1'b1;
`ifdef FETCH_HALT_DETECT_EN
      halted_q   <= 1'b0;
`endif
    end else begin
      rst_q <= 1'b0;
      if (redirect) begin
        // Same-cycle completion and pop are dropped; kill aborts the in-flight request.
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
        fetch_pc_q <= {redirect_pc[31:2], 2'b00};
        kill_q     <= 1'b1;
`ifdef FETCH_HALT_DETECT_EN
        halted_q   <= 1'b0;
`endif
      end else begin
        kill_q  <= 1'b0;
        count_q <= count_d;
        if (push) begin
          tail_q     <= tail_q + PtrW'(1);
          fetch_pc_q <= fetch_pc_q + 32'd4;
`ifdef FETCH_HALT_DETECT_EN
          if (fetch_pc_q == HALT_PC) begin
            halted_q <= 1'b1;
          end
`endif
        end
        if (pop) begin
          head_q <= head_q + PtrW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !redirect && push) begin
      pc_mem_q[tail_q]    <= fetch_pc_q;
      instr_mem_q[tail_q] <= imem_rdata;
    end
  end

`ifdef FETCH_HALT_DETECT_EN
  logic unused_bits;
  assign unused_bits = ^redirect_pc[1:0];
`else
  assign halted_q = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{redirect_pc[1:0], HALT_PC};
`endif

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Directed plus randomized bench for mips32_fetch_queue against a queue-based
// reference model of the fetch/FIFO/redirect rules.
module tb_mips32_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] HALT_PC  = 32'h8;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halted;

  always #5 clock = ~clock;

  mips32_fetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC),
    .HALT_PC (HALT_PC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_out  (instr_out),
    .pc_out     (pc_out),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halted     (halted)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: queue of {pc, instr} plus fetch state.
  logic [63:0] q[$];
  logic [31:0] m_pc     = RESET_PC;
  bit          m_kill   = 1'b0;
  bit          m_rst    = 1'b1;
  bit          m_halted = 1'b0;

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  function automatic bit exp_req();
    return !m_rst && !m_kill && !m_halted && (q.size() < DEPTH);
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] e_instr, e_pc;
    e_instr = (q.size() != 0) ? q[0][31:0] : 32'h0;
    e_pc    = (q.size() != 0) ? q[0][63:32] : 32'h0;
    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req()});
    check("imem_addr", imem_addr, m_pc);
    check("instr_valid", {31'b0, instr_valid}, {31'b0, q.size() != 0});
    check("instr_out", instr_out, e_instr);
    check("pc_out", pc_out, e_pc);
    check("halted", {31'b0, halted}, {31'b0, m_halted});
  endtask

  task automatic step(input bit rst, input bit redir, input logic [31:0] rpc,
                      input bit ack, input logic [31:0] rd, input bit rdy);
    bit req;
    reset       = rst;
    redirect    = redir;
    redirect_pc = rpc;
    imem_ack    = ack;
    imem_rdata  = rd;
    instr_ready = rdy;
    @(posedge clock);
    if (rst) begin
      q.delete();
      m_pc     = RESET_PC;
      m_kill   = 1'b0;
      m_rst    = 1'b1;
      m_halted = 1'b0;
    end else begin
      req   = exp_req();
      m_rst = 1'b0;
      if (redir) begin
        q.delete();
        m_pc     = {rpc[31:2], 2'b00};
        m_kill   = 1'b1;
        m_halted = 1'b0;
      end else begin
        m_kill = 1'b0;
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (req && ack) begin
          q.push_back({m_pc, rd});
          if (HaltEn && m_pc == HALT_PC) m_halted = 1'b1;
          m_pc = m_pc + 32'd4;
        end
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    int r;
    logic [31:0] rpc;

    // Reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 32'hDEAD, 1);
    check("reset_req", {31'b0, imem_req}, 32'h0);
    check("reset_valid", {31'b0, instr_valid}, 32'h0);

    // Streaming: ack every cycle, core always ready
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, $urandom(), 1);

    // Fill with core stalled, then release one slot
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, $urandom(), 0);
    check("full_req_low", {31'b0, imem_req}, 32'h0);
    step(0, 0, 0, 1, $urandom(), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, $urandom(), 0);

    // Redirect to 0x43 with a same-cycle ack
    step(0, 1, 32'h43, 1, 32'hBAD0BAD0, 1);
    check("redir_req_low", {31'b0, imem_req}, 32'h0);
    check("redir_empty", {31'b0, instr_valid}, 32'h0);
    check("redir_addr", imem_addr, 32'h40);
    step(0, 0, 0, 1, 32'h1111, 0);
    step(0, 0, 0, 1, 32'h2222, 0);
    check("redir_first_pc", pc_out, 32'h40);
    check("redir_first_instr", instr_out, 32'h2222);

    // Wrap at top of address space
    step(0, 1, 32'hFFFFFFFC, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'hA0A0, 0);
    check("wrap_addr", imem_addr, 32'h0);
    step(0, 0, 0, 1, 32'hB0B0, 0);
    check("wrap_head_pc", pc_out, 32'hFFFFFFFC);
    step(0, 0, 0, 0, 0, 1);
    check("wrap_second_pc", pc_out, 32'h0);
    step(0, 0, 0, 0, 0, 1);

    // Delayed ack: request held three cycles
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'hC0DE, 0);

    // Halt detection from PC 0
    step(0, 1, 32'h0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, $urandom(), 0);
    check("halt_flag", {31'b0, halted}, {31'b0, HaltEn});
    step(0, 0, 0, 1, $urandom(), 1);
    step(0, 1, 32'h0, 0, 0, 1);
    check("halt_cleared", {31'b0, halted}, 32'h0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, $urandom(), 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(3);
      case (r)
        0:       rpc = $urandom_range(15);
        1:       rpc = 32'hFFFFFFF0 | $urandom_range(15);
        default: rpc = $urandom();
      endcase
      step(($urandom_range(99) == 0), ($urandom_range(19) == 0), rpc,
           ($urandom_range(9) < 6), $urandom(), ($urandom_range(1) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
